// File: rtl/nes_controller_responder.sv
// NES controller responder: emulates one game pad on the latch/clock/data link.
// Buttons are captured while latch is high and then shifted out MSB first,
// active-low, one bit per console clock rise. Pins are asynchronous to clk
// and pass through a synchroniser plus history flop for edge detection.
module nes_controller_responder #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] buttons,
    input  logic       nes_latch,
    input  logic       nes_clk,
    output logic       nes_data,
    output logic [7:0] snapshot,
    output logic [3:0] bit_count,
    output logic       frame_done,
    output logic       timeout_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(SYNC_STAGES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW-1:0] ARM_LAST     = AW'(SYNC_STAGES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    logic [SYNC_STAGES-1:0] latch_sync_q;
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic                   latch_hist_q;
    logic                   clk_hist_q;
    logic [AW-1:0]          arm_cnt_q;
    logic                   armed_q;

    state_t                 state_q;
    logic [7:0]             shift_q;
    logic                   data_q;
    logic [7:0]             snapshot_q;
    logic [3:0]             bit_count_q;
    logic                   frame_done_q;
    logic                   timeout_err_q;
    logic [TW-1:0]          tmo_q;

    logic latch_lvl;
    logic clk_lvl;
    logic latch_rise;
    logic latch_fall;
    logic clk_rise;

    // Synchroniser chains and edge-history flops for both console pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            latch_sync_q <= '0;
            clk_sync_q   <= '0;
            latch_hist_q <= 1'b0;
            clk_hist_q   <= 1'b0;
        end else begin
            latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], nes_latch};
            clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], nes_clk};
            latch_hist_q <= latch_sync_q[SYNC_STAGES-1];
            clk_hist_q   <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    // Edge detection stays disarmed until the chain and history flop have
    // filled after reset, so a latch already high at reset release is not a rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            arm_cnt_q <= '0;
            armed_q   <= 1'b0;
        end else if (!armed_q) begin
            if (arm_cnt_q == ARM_LAST) begin
                armed_q <= 1'b1;
            end else begin
                arm_cnt_q <= arm_cnt_q + AW'(1);
            end
        end
    end

    assign latch_lvl  = latch_sync_q[SYNC_STAGES-1];
    assign clk_lvl    = clk_sync_q[SYNC_STAGES-1];
    assign latch_rise = armed_q &  latch_lvl & ~latch_hist_q;
    assign latch_fall = armed_q & ~latch_lvl &  latch_hist_q;
    assign clk_rise   = armed_q &  clk_lvl   & ~clk_hist_q;

    // Frame FSM: latch rise wins over everything, then per-state behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            shift_q       <= 8'h00;
            data_q        <= 1'b1;
            snapshot_q    <= 8'h00;
            bit_count_q   <= 4'd0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            tmo_q         <= '0;
        end else begin
            frame_done_q <= 1'b0;
            if (latch_rise) begin
                // Abandons any partial frame silently.
                state_q       <= S_LOAD;
                shift_q       <= buttons;
                data_q        <= ~buttons[7];
                bit_count_q   <= 4'd0;
                timeout_err_q <= 1'b0;
                tmo_q         <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        data_q <= 1'b1;
                    end
                    S_LOAD: begin
                        // Clock edges are ignored here; a coincident latch fall
                        // therefore enters SHIFT with the register unshifted.
                        if (latch_fall) begin
                            state_q    <= S_SHIFT;
                            snapshot_q <= shift_q;
                            data_q     <= ~shift_q[7];
                            tmo_q      <= '0;
                        end else begin
                            shift_q <= buttons;
                            data_q  <= ~buttons[7];
                        end
                    end
                    S_SHIFT: begin
                        if (clk_rise) begin
                            shift_q     <= {shift_q[6:0], 1'b0};
                            bit_count_q <= bit_count_q + 4'd1;
                            tmo_q       <= '0;
                            if (bit_count_q == 4'd7) begin
                                frame_done_q <= 1'b1;
                                state_q      <= S_DONE;
                                data_q       <= 1'b0;
                            end else begin
                                data_q <= ~shift_q[6];
                            end
                        end else if (tmo_q == TIMEOUT_LAST) begin
                            timeout_err_q <= 1'b1;
                            frame_done_q  <= 1'b1;
                            state_q       <= S_IDLE;
                            data_q        <= 1'b1;
                            tmo_q         <= '0;
                        end else begin
                            tmo_q <= tmo_q + TW'(1);
                        end
                    end
                    S_DONE: begin
                        // Serial-in of the shift register is tied low: extra
                        // bits read as pressed, and bit_count holds at 8.
                        data_q <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign nes_data    = data_q;
    assign snapshot    = snapshot_q;
    assign bit_count   = bit_count_q;
    assign frame_done  = frame_done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_nes_controller_responder.sv
// Directed bench for nes_controller_responder: drives latch/clock frames at
// console-like timing and checks serial data, snapshot, counts and flags.
`timescale 1ns/1ps
module tb_nes_controller_responder;

    localparam int LATCH_NS = 12000;
    localparam int HALF_NS  = 6000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] buttons = 8'h00;
    logic       nes_latch = 1'b0;
    logic       nes_clk = 1'b0;
    logic       nes_data;
    logic [7:0] snapshot;
    logic [3:0] bit_count;
    logic       frame_done;
    logic       timeout_err;

    int check_count = 0;
    int pass_count  = 0;
    int fd_count    = 0;

    nes_controller_responder dut (
        .clk         (clk),
        .reset       (reset),
        .buttons     (buttons),
        .nes_latch   (nes_latch),
        .nes_clk     (nes_clk),
        .nes_data    (nes_data),
        .snapshot    (snapshot),
        .bit_count   (bit_count),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    always #20 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done === 1'b1) fd_count++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_latch(input logic [7:0] b);
        buttons   = b;
        nes_latch = 1'b1;
        #LATCH_NS;
        nes_latch = 1'b0;
        #HALF_NS;
    endtask

    // Reads bit 0 now, then issues n clock pulses, reading after each (up to 7).
    task automatic read_bits(input int n, output logic [7:0] seen);
        seen    = 8'h00;
        seen[7] = nes_data;
        for (int i = 1; i <= n; i++) begin
            nes_clk = 1'b1;
            #HALF_NS;
            nes_clk = 1'b0;
            #HALF_NS;
            if (i < 8) seen[7-i] = nes_data;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_clks(3);
        check_count++;
        if (nes_data !== 1'b1) $display("FAIL reset_data got=%b exp=1", nes_data); else pass_count++;
        check_count++;
        if (snapshot !== 8'h00) $display("FAIL reset_snapshot got=%h exp=00", snapshot); else pass_count++;
        check_count++;
        if (bit_count !== 4'd0) $display("FAIL reset_bit_count got=%0d exp=0", bit_count); else pass_count++;
        check_count++;
        if (frame_done !== 1'b0) $display("FAIL reset_frame_done got=%b exp=0", frame_done); else pass_count++;
        check_count++;
        if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); else pass_count++;
        reset = 1'b0;
        wait_clks(5);
        $display("reset: data=%b snapshot=%h bit_count=%0d", nes_data, snapshot, bit_count);
    endtask

    task automatic test_frame();
        logic [7:0] seen;
        int fd0;
        fd0 = fd_count;
        do_latch(8'hA5);
        seen    = 8'h00;
        seen[7] = nes_data;
        // First pulse measures pin-to-data latency (3 clk).
        wait_clks(1);
        nes_clk = 1'b1;
        wait_clks(2);
        check_count++;
        if (nes_data !== 1'b0) $display("FAIL latency_early got=%b exp=0", nes_data); else pass_count++;
        wait_clks(1);
        check_count++;
        if (nes_data !== 1'b1) $display("FAIL latency_edge got=%b exp=1", nes_data); else pass_count++;
        #HALF_NS;
        nes_clk = 1'b0;
        #HALF_NS;
        seen[6] = nes_data;
        for (int i = 2; i <= 7; i++) begin
            nes_clk = 1'b1;
            #HALF_NS;
            nes_clk = 1'b0;
            #HALF_NS;
            seen[7-i] = nes_data;
        end
        check_count++;
        if (fd_count - fd0 !== 0) $display("FAIL frame_done_before_8th got=%0d exp=0", fd_count - fd0); else pass_count++;
        nes_clk = 1'b1;
        #HALF_NS;
        nes_clk = 1'b0;
        #HALF_NS;
        check_count++;
        if (seen !== 8'h5A) $display("FAIL frame_bits got=%b exp=01011010", seen); else pass_count++;
        check_count++;
        if (snapshot !== 8'hA5) $display("FAIL frame_snapshot got=%h exp=a5", snapshot); else pass_count++;
        check_count++;
        if (bit_count !== 4'd8) $display("FAIL frame_bit_count got=%0d exp=8", bit_count); else pass_count++;
        check_count++;
        if (fd_count - fd0 !== 1) $display("FAIL frame_done_count got=%0d exp=1", fd_count - fd0); else pass_count++;
        $display("frame: buttons=a5 bits=%b snapshot=%h bit_count=%0d", seen, snapshot, bit_count);
    endtask

    task automatic test_extra_clocks();
        int fd0;
        fd0 = fd_count;
        for (int i = 0; i < 3; i++) begin
            nes_clk = 1'b1;
            #HALF_NS;
            nes_clk = 1'b0;
            #HALF_NS;
            check_count++;
            if (nes_data !== 1'b0) $display("FAIL extra_data%0d got=%b exp=0", i, nes_data); else pass_count++;
        end
        check_count++;
        if (bit_count !== 4'd8) $display("FAIL extra_bit_count got=%0d exp=8", bit_count); else pass_count++;
        check_count++;
        if (fd_count - fd0 !== 0) $display("FAIL extra_frame_done got=%0d exp=0", fd_count - fd0); else pass_count++;
        $display("extra clocks: data=%b bit_count=%0d", nes_data, bit_count);
    endtask

    task automatic test_abort();
        logic [7:0] seen;
        int fd0;
        fd0 = fd_count;
        do_latch(8'hA5);
        read_bits(4, seen);
        buttons   = 8'h10;
        nes_latch = 1'b1;
        #HALF_NS;
        check_count++;
        if (bit_count !== 4'd0) $display("FAIL abort_bit_count got=%0d exp=0", bit_count); else pass_count++;
        check_count++;
        if (fd_count - fd0 !== 0) $display("FAIL abort_frame_done got=%0d exp=0", fd_count - fd0); else pass_count++;
        #HALF_NS;
        nes_latch = 1'b0;
        #HALF_NS;
        read_bits(8, seen);
        check_count++;
        if (seen !== 8'hEF) $display("FAIL abort_new_bits got=%b exp=11101111", seen); else pass_count++;
        check_count++;
        if (snapshot !== 8'h10) $display("FAIL abort_snapshot got=%h exp=10", snapshot); else pass_count++;
        check_count++;
        if (fd_count - fd0 !== 1) $display("FAIL abort_frame_done_total got=%0d exp=1", fd_count - fd0); else pass_count++;
        $display("abort: new bits=%b snapshot=%h", seen, snapshot);
    endtask

    task automatic test_timeout();
        logic [7:0] seen;
        int fd0;
        do_latch(8'h3C);
        read_bits(2, seen);
        fd0 = fd_count;
        wait_clks(3000);
        check_count++;
        if (timeout_err !== 1'b0) $display("FAIL timeout_early got=%b exp=0", timeout_err); else pass_count++;
        for (int i = 0; i < 2000 && timeout_err !== 1'b1; i++) wait_clks(1);
        check_count++;
        if (timeout_err !== 1'b1) $display("FAIL timeout_err got=%b exp=1", timeout_err); else pass_count++;
        wait_clks(2);
        check_count++;
        if (fd_count - fd0 !== 1) $display("FAIL timeout_frame_done got=%0d exp=1", fd_count - fd0); else pass_count++;
        check_count++;
        if (nes_data !== 1'b1) $display("FAIL timeout_idle_data got=%b exp=1", nes_data); else pass_count++;
        nes_latch = 1'b1;
        buttons   = 8'h3C;
        wait_clks(6);
        check_count++;
        if (timeout_err !== 1'b0) $display("FAIL timeout_clear got=%b exp=0", timeout_err); else pass_count++;
        #LATCH_NS;
        nes_latch = 1'b0;
        #HALF_NS;
        read_bits(8, seen);
        check_count++;
        if (seen !== 8'hC3) $display("FAIL timeout_next_frame got=%b exp=11000011", seen); else pass_count++;
        $display("timeout: err cleared, next frame bits=%b", seen);
    endtask

    task automatic test_latch_hold();
        logic [7:0] seen;
        buttons   = 8'h00;
        nes_latch = 1'b1;
        wait_clks(10);
        check_count++;
        if (nes_data !== 1'b1) $display("FAIL hold_a_released got=%b exp=1", nes_data); else pass_count++;
        buttons[7] = 1'b1;
        wait_clks(4);
        check_count++;
        if (nes_data !== 1'b0) $display("FAIL hold_a_pressed got=%b exp=0", nes_data); else pass_count++;
        buttons[7] = 1'b0;
        wait_clks(4);
        check_count++;
        if (nes_data !== 1'b1) $display("FAIL hold_a_released2 got=%b exp=1", nes_data); else pass_count++;
        for (int i = 0; i < 2; i++) begin
            nes_clk = 1'b1;
            wait_clks(10);
            nes_clk = 1'b0;
            wait_clks(10);
        end
        check_count++;
        if (bit_count !== 4'd0) $display("FAIL hold_clk_ignored got=%0d exp=0", bit_count); else pass_count++;
        buttons = 8'h81;
        wait_clks(10);
        nes_latch = 1'b0;
        #HALF_NS;
        read_bits(8, seen);
        check_count++;
        if (seen !== 8'h7E) $display("FAIL hold_frame_bits got=%b exp=01111110", seen); else pass_count++;
        check_count++;
        if (snapshot !== 8'h81) $display("FAIL hold_snapshot got=%h exp=81", snapshot); else pass_count++;
        $display("latch hold: bits=%b snapshot=%h", seen, snapshot);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] seen;
        int fd0;
        do_latch(8'hFF);
        read_bits(5, seen);
        check_count++;
        if (bit_count !== 4'd5) $display("FAIL mid_bit_count got=%0d exp=5", bit_count); else pass_count++;
        wait_clks(1);
        reset = 1'b1;
        wait_clks(1);
        reset = 1'b0;
        check_count++;
        if (nes_data !== 1'b1) $display("FAIL mid_reset_data got=%b exp=1", nes_data); else pass_count++;
        check_count++;
        if (bit_count !== 4'd0) $display("FAIL mid_reset_bit_count got=%0d exp=0", bit_count); else pass_count++;
        check_count++;
        if (snapshot !== 8'h00) $display("FAIL mid_reset_snapshot got=%h exp=00", snapshot); else pass_count++;
        wait_clks(10);
        fd0 = fd_count;
        do_latch(8'h5A);
        read_bits(8, seen);
        check_count++;
        if (seen !== 8'hA5) $display("FAIL mid_next_bits got=%b exp=10100101", seen); else pass_count++;
        check_count++;
        if (snapshot !== 8'h5A) $display("FAIL mid_next_snapshot got=%h exp=5a", snapshot); else pass_count++;
        check_count++;
        if (fd_count - fd0 !== 1) $display("FAIL mid_next_frame_done got=%0d exp=1", fd_count - fd0); else pass_count++;
        $display("reset mid-frame: next bits=%b snapshot=%h", seen, snapshot);
    endtask

    initial begin
        #7;
        test_reset();
        test_frame();
        test_extra_clocks();
        test_abort();
        test_timeout();
        test_latch_hold();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
